// File: rtl/vmem_pkg.sv
// Shared types for the vpipe data-memory port arbiter: FSM states,
// requester indices and the one-hot grant vector.
package vmem_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned P0    = 0;
    localparam int unsigned P1    = 1;
    localparam int unsigned CNT_W = 3;

    typedef logic [1:0] grant_t;

endpackage

// File: rtl/vmem_grant_sel.sv
// Combinational grant picker: port 0 wins unless port 1 has waited
// through MAX_BURST consecutive port-0 grants.
module vmem_grant_sel
    import vmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic [1:0]       i_valid,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output grant_t           o_grant
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_BURST);

    always_comb begin
        o_grant = '0;
        if (i_valid[P0] && i_valid[P1]) begin
            if (i_starve_cnt >= LP_MAX) begin
                o_grant[P1] = 1'b1;
            end else begin
                o_grant[P0] = 1'b1;
            end
        end else if (i_valid[P0]) begin
            o_grant[P0] = 1'b1;
        end else if (i_valid[P1]) begin
            o_grant[P1] = 1'b1;
        end
    end

endmodule

// File: rtl/vmem_port_arbiter.sv
// Two-requester arbiter in front of the 1R1W data memory: fixed port-0
// priority with a starvation escape for port 1, and a hold freeze.
module vmem_port_arbiter
    import vmem_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic             p0_we,
    input  logic [AW-1:0]    p0_addr,
    input  logic [DW-1:0]    p0_wdata,
    output logic             p0_rvalid,
    output logic [DW-1:0]    p0_rdata,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic             p1_we,
    input  logic [AW-1:0]    p1_addr,
    input  logic [DW-1:0]    p1_wdata,
    output logic             p1_rvalid,
    output logic [DW-1:0]    p1_rdata,
    output logic             mem_w_en,
    output logic [AW-1:0]    mem_w_addr,
    output logic [DW-1:0]    mem_w_data,
    output logic             mem_r_en,
    output logic [AW-1:0]    mem_r_addr,
    input  logic [DW-1:0]    mem_r_data,
    output logic [CNT_W-1:0] starve_cnt
);

    state_t           r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_p0_rvalid;
    logic             r_p1_rvalid;
    logic [DW-1:0]    r_p0_rdata;
    logic [DW-1:0]    r_p1_rdata;

    logic             w_arb_en;
    grant_t           w_pick;
    grant_t           w_gnt;
    logic [1:0]       w_rd_gnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    vmem_grant_sel #(
        .MAX_BURST(MAX_BURST)
    ) u_grant_sel (
        .i_valid     ({p1_valid, p0_valid}),
        .i_starve_cnt(r_starve_cnt),
        .o_grant     (w_pick)
    );

    // Reset and the hold input gate the grant combinationally, so ready and
    // the memory enables drop in the very cycle either one asserts.
    assign w_arb_en = rst && (r_state == ARB) && !hold;
    assign w_gnt    = w_arb_en ? w_pick : '0;
    assign p0_ready = w_gnt[P0];
    assign p1_ready = w_gnt[P1];

    always_comb begin
        mem_w_en   = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        mem_r_en   = 1'b0;
        mem_r_addr = '0;
        w_rd_gnt   = '0;
        if (w_gnt[P0]) begin
            if (p0_we) begin
                mem_w_en   = 1'b1;
                mem_w_addr = p0_addr;
                mem_w_data = p0_wdata;
            end else begin
                mem_r_en     = 1'b1;
                mem_r_addr   = p0_addr;
                w_rd_gnt[P0] = 1'b1;
            end
        end else if (w_gnt[P1]) begin
            if (p1_we) begin
                mem_w_en   = 1'b1;
                mem_w_addr = p1_addr;
                mem_w_data = p1_wdata;
            end else begin
                mem_r_en     = 1'b1;
                mem_r_addr   = p1_addr;
                w_rd_gnt[P1] = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_nxt = r_starve_cnt;
        if (!p1_valid || w_gnt[P1]) begin
            w_cnt_nxt = '0;
        end else if (w_gnt[P0]) begin
            w_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB;
            r_starve_cnt <= '0;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            // Responses are independent of hold: a read granted just before
            // hold rises still completes.
            r_p0_rvalid <= w_rd_gnt[P0];
            r_p1_rvalid <= w_rd_gnt[P1];
            if (w_rd_gnt[P0]) begin
                r_p0_rdata <= mem_r_data;
            end
            if (w_rd_gnt[P1]) begin
                r_p1_rdata <= mem_r_data;
            end
            case (r_state)
                ARB: begin
                    if (hold) begin
                        r_state <= HOLD;
                    end else begin
                        r_starve_cnt <= w_cnt_nxt;
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign p0_rvalid  = r_p0_rvalid;
    assign p1_rvalid  = r_p1_rvalid;
    assign p0_rdata   = r_p0_rdata;
    assign p1_rdata   = r_p1_rdata;
    assign starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Scoreboard bench for vmem_port_arbiter: directed vectors push expected
// read responses; a negedge monitor pops and compares them on rvalid.
module tb_vmem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic       p0_valid, p0_ready, p0_we, p0_rvalid;
    logic [7:0] p0_addr, p0_wdata, p0_rdata;
    logic       p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [7:0] p1_addr, p1_wdata, p1_rdata;
    logic       mem_w_en, mem_r_en;
    logic [7:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;
    logic [2:0] starve_cnt;

    logic [7:0] mem [256];

    typedef struct {
        logic [7:0]  d;
        int unsigned due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_r_data = mem[mem_r_addr];
    always @(posedge clk) if (mem_w_en) mem[mem_w_addr] <= mem_w_data;

    vmem_port_arbiter #(
        .AW(8),
        .DW(8),
        .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .starve_cnt(starve_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic v1, input logic we1, input logic [7:0] a1, input logic [7:0] d1,
                         input logic h);
        p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
        hold = h;
    endtask

    task automatic push0(input logic [7:0] d);
        exp_t e;
        e.d = d; e.due = cyc + 1;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [7:0] d);
        exp_t e;
        e.d = d; e.due = cyc + 1;
        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (p0_rvalid) begin
            if (q0.size() == 0) begin
                chk("p0_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("p0_rvalid_cycle", cyc, e.due);
                chk("p0_rdata", {24'd0, p0_rdata}, {24'd0, e.d});
            end
        end
        if (p1_rvalid) begin
            if (q1.size() == 0) begin
                chk("p1_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("p1_rvalid_cycle", cyc, e.due);
                chk("p1_rdata", {24'd0, p1_rdata}, {24'd0, e.d});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int exp_g3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp_c3[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h30] = 8'h11;
        mem[8'h31] = 8'h22;
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
        @(negedge clk);
        chk("reset_p0_ready", p0_ready, 0);
        chk("reset_p1_ready", p1_ready, 0);
        chk("reset_mem_en", {mem_w_en, mem_r_en}, 0);
        chk("reset_rvalid", {p0_rvalid, p1_rvalid}, 0);
        chk("reset_rdata", {p0_rdata, p1_rdata}, 0);
        chk("reset_starve_cnt", starve_cnt, 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        rst = 1'b1;
        step();

        // p0 read alone, latency one, rdata holds afterwards
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        push0(8'hA5);
        @(negedge clk);
        chk("t2_p0_ready", p0_ready, 1);
        chk("t2_p1_ready", p1_ready, 0);
        chk("t2_mem_r_en", mem_r_en, 1);
        chk("t2_mem_r_addr", mem_r_addr, 8'h10);
        chk("t2_mem_w_en", mem_w_en, 0);
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk("t2_idle_mem_r_addr", mem_r_addr, 8'h00);
        step();
        @(negedge clk);
        chk("t2_rvalid_one_cycle", p0_rvalid, 0);
        chk("t2_rdata_hold", p0_rdata, 8'hA5);
        step();

        // both valid: starvation pattern p0 x4 then p1
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
            if (exp_g3[i] == 1) push1(8'h22);
            else push0(8'h11);
            @(negedge clk);
            chk($sformatf("t3_p0_ready_%0d", i), p0_ready, (exp_g3[i] == 0));
            chk($sformatf("t3_p1_ready_%0d", i), p1_ready, (exp_g3[i] == 1));
            step();
            chk($sformatf("t3_starve_cnt_%0d", i), starve_cnt, exp_c3[i]);
        end

        // write then read-after-write from the other port
        drive(1'b1, 1'b1, 8'h20, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk("t4_p0_ready", p0_ready, 1);
        chk("t4_mem_w_en", mem_w_en, 1);
        chk("t4_mem_w_addr", mem_w_addr, 8'h20);
        chk("t4_mem_w_data", mem_w_data, 8'h5A);
        chk("t4_mem_r_en", mem_r_en, 0);
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        push1(8'h5A);
        @(negedge clk);
        chk("t4_p1_ready", p1_ready, 1);
        chk("t4_mem_r_addr", mem_r_addr, 8'h20);
        step();

        // hold: freeze grants, earlier read completes, counter retained
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
            push0(8'h11);
            step();
        end
        chk("t5_cnt_before_hold", starve_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00, 1'b1);
            @(negedge clk);
            chk($sformatf("t5_hold_ready_%0d", i), {p0_ready, p1_ready}, 0);
            chk($sformatf("t5_hold_en_%0d", i), {mem_w_en, mem_r_en}, 0);
            step();
            chk($sformatf("t5_hold_cnt_%0d", i), starve_cnt, 2);
        end
        drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
        @(negedge clk);
        chk("t5_release_ready", {p0_ready, p1_ready}, 0);
        step();
        push0(8'h11);
        @(negedge clk);
        chk("t5_resume_p0_ready", p0_ready, 1);
        step();
        chk("t5_resume_cnt", starve_cnt, 3);

        // p1 alone back-to-back
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
            push1(8'h22);
            @(negedge clk);
            chk($sformatf("t6_p1_ready_%0d", i), p1_ready, 1);
            chk($sformatf("t6_p0_ready_%0d", i), p0_ready, 0);
            step();
            chk($sformatf("t6_cnt_%0d", i), starve_cnt, 0);
        end

        // mid-traffic reset drops pending rvalid and clears the counter
        drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
        push0(8'h11);
        step();
        @(negedge clk);
        chk("t1_pre_reset_ready", p0_ready, 1);
        step();
        chk("t1_pre_reset_cnt", starve_cnt, 2);
        rst = 1'b0;
        #1;
        chk("t1_reset_rvalid", {p0_rvalid, p1_rvalid}, 0);
        chk("t1_reset_ready", {p0_ready, p1_ready}, 0);
        chk("t1_reset_en", {mem_w_en, mem_r_en}, 0);
        chk("t1_reset_cnt", starve_cnt, 0);
        chk("t1_reset_rdata", {p0_rdata, p1_rdata}, 0);
        @(negedge clk);
        chk("t1_reset_ready_negedge", {p0_ready, p1_ready}, 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
